// File: rtl/vga_mem_arbiter.sv
// Arbiter that shares one synchronous RAM between a VGA fetch port and a CPU port.
// The VGA port always wins. Define STALL_COUNT_EN to count the cycles the CPU spends stalled.
module vga_mem_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vga_window,
  input  logic [15:0] vga_addr,
  output logic [15:0] vga_data,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [15:0] cpu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_ACK  = 2'd1,
    RD_WAIT = 2'd2,
    RD_ACK  = 2'd3
  } state_t;

  // CPU handshake: cpu_req stays high until cpu_ack; cpu_ack is a single-cycle pulse,
  // one cycle after a write is accepted or two cycles after a read is accepted.
  state_t      state_q, state_d;
  logic [15:0] rdata_q, rdata_d;
  logic        stall;

  assign vga_data  = mem_rdata;
  assign cpu_rdata = rdata_q;
  assign stall     = (state_q == IDLE) && cpu_req && vga_window;

  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata_q;
    mem_addr  = cpu_addr;
    mem_we    = 1'b0;
    mem_wdata = cpu_wdata;
    cpu_ack   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && !vga_window) begin
          mem_we  = cpu_we;
          state_d = cpu_we ? WR_ACK : RD_WAIT;
        end
      end
      WR_ACK: begin
        cpu_ack = 1'b1;
        state_d = IDLE;
      end
      RD_WAIT: begin
        // RAM data for the accepted read arrives now, whoever owns the address bus.
        rdata_d = mem_rdata;
        state_d = RD_ACK;
      end
      RD_ACK: begin
        cpu_ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (vga_window) begin
      mem_addr = vga_addr;
      mem_we   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (stall && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= 16'h0000;
    else        stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_count  = 16'h0000;
`endif

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Bench for vga_mem_arbiter: directed table, multi-cycle corner sequences and random
// CPU/VGA traffic checked against a shadow-memory model of the RAM.
module tb_vga_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vga_window;
  logic [15:0] vga_addr;
  logic [15:0] vga_data;
  logic        cpu_req;
  logic        cpu_we;
  logic [15:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [15:0] stall_count;

  always #5 clk = ~clk;

  vga_mem_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_window  (vga_window),
    .vga_addr    (vga_addr),
    .vga_data    (vga_data),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rdata   (cpu_rdata),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .stall_count (stall_count)
  );

  // Synchronous RAM with one-cycle read latency.
  logic [15:0] ram [65536];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  // Reference model: what every address should hold, plus total stalled cycles since reset.
  logic [15:0] model_mem [65536];
  int          stall_total = 0;
  int          n_checks = 0;
  int          n_err = 0;

  typedef struct {
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          stall;
    int          exp_lat;
    logic [15:0] exp_rdata;
  } vec_t;

  vec_t vecs [5];

  function automatic logic [15:0] init_val(input int a);
    return 16'(a * 7) ^ 16'h5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_stall(input int n);
    stall_total = stall_total + n;
    if (stall_total > 65535) stall_total = 65535;
  endtask

  task automatic check_stall_count(input string name);
`ifdef STALL_COUNT_EN
    chk(name, {16'h0, stall_count}, stall_total);
`else
    chk(name, {16'h0, stall_count}, 32'h0);
`endif
  endtask

  // One CPU transaction; the window is held high for `stall` cycles before the request can go.
  task automatic cpu_op(input bit we, input logic [15:0] addr, input logic [15:0] wd,
                        input int stall, output int lat, output logic [15:0] rd);
    int bad;
    bad = 0;
    lat = 0;
    rd  = 16'hxxxx;
    step();
    cpu_req    = 1'b1;
    cpu_we     = we;
    cpu_addr   = addr;
    cpu_wdata  = wd;
    vga_window = (stall > 0);
    vga_addr   = 16'h0000;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (mem_we !== 1'b0 || cpu_ack !== 1'b0) bad++;
      step();
    end
    add_stall(stall);
    vga_window = 1'b0;
    @(negedge clk);
    chk("accept_we", {31'h0, mem_we}, {31'h0, we});
    chk("accept_addr", {16'h0, mem_addr}, {16'h0, addr});
    if (we) chk("accept_wdata", {16'h0, mem_wdata}, {16'h0, wd});
    if (stall > 0) chk("stall_quiet", bad, 0);
    for (int c = 1; c <= 8; c++) begin
      step();
      @(negedge clk);
      if (cpu_ack === 1'b1) begin
        lat = c;
        rd  = cpu_rdata;
        break;
      end
    end
    if (we) model_mem[addr] = wd;
    step();
    cpu_req = 1'b0;
    @(negedge clk);
    chk("ack_single_pulse", {31'h0, cpu_ack}, 32'h0);
    if (!we && lat != 0) chk("rdata_hold", {16'h0, cpu_rdata}, {16'h0, rd});
  endtask

  // One VGA fetch cycle: address passes straight through, data appears a cycle later.
  task automatic vga_probe(input logic [15:0] a);
    step();
    cpu_req    = 1'b0;
    vga_window = 1'b1;
    vga_addr   = a;
    @(negedge clk);
    chk("vga_mem_addr", {16'h0, mem_addr}, {16'h0, a});
    chk("vga_mem_we", {31'h0, mem_we}, 32'h0);
    step();
    vga_window = 1'b0;
    @(negedge clk);
    chk("vga_data", {16'h0, vga_data}, {16'h0, model_mem[a]});
  endtask

  initial begin
    int          lat;
    logic [15:0] rd;
    logic [15:0] a;
    bit          we;

    for (int i = 0; i < 65536; i++) begin
      ram[i]       = init_val(i);
      model_mem[i] = init_val(i);
    end
    ram[16'h0F0E]       = 16'h0050;
    model_mem[16'h0F0E] = 16'h0050;

    vecs[0] = '{we: 1'b1, addr: 16'h0F0F, wdata: 16'h1234, stall: 0,  exp_lat: 1, exp_rdata: 16'h0000};
    vecs[1] = '{we: 1'b0, addr: 16'h0F0E, wdata: 16'h0000, stall: 0,  exp_lat: 2, exp_rdata: 16'h0050};
    vecs[2] = '{we: 1'b0, addr: 16'h0F0F, wdata: 16'h0000, stall: 10, exp_lat: 2, exp_rdata: 16'h1234};
    vecs[3] = '{we: 1'b1, addr: 16'h0F10, wdata: 16'hBEEF, stall: 2,  exp_lat: 1, exp_rdata: 16'h0000};
    vecs[4] = '{we: 1'b0, addr: 16'h0F10, wdata: 16'h0000, stall: 1,  exp_lat: 2, exp_rdata: 16'hBEEF};

    rst_n = 1'b0; vga_window = 1'b0; vga_addr = 16'h0; cpu_req = 1'b0;
    cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
    #12;
    chk("rst_ack", {31'h0, cpu_ack}, 32'h0);
    chk("rst_rdata", {16'h0, cpu_rdata}, 32'h0);
    chk("rst_stall", {16'h0, stall_count}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    rst_n = 1'b1;

    // Directed transactions.
    for (int i = 0; i < 5; i++) begin
      cpu_op(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].stall, lat, rd);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), {16'h0, rd}, {16'h0, vecs[i].exp_rdata});
    end
    vga_probe(16'h0F0F);
    chk("vga_sees_cpu_write", {16'h0, vga_data}, 32'h1234);
    check_stall_count("stall_after_table");

    // Read in flight while the window opens on the next cycle.
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0F0E;
    @(negedge clk);
    chk("inflight_accept_addr", {16'h0, mem_addr}, 32'h0F0E);
    step();
    vga_window = 1'b1; vga_addr = 16'h0FF0;
    @(negedge clk);
    chk("inflight_vga_addr", {16'h0, mem_addr}, 32'h0FF0);
    chk("inflight_no_ack", {31'h0, cpu_ack}, 32'h0);
    step();
    @(negedge clk);
    chk("inflight_ack", {31'h0, cpu_ack}, 32'h1);
    chk("inflight_rdata", {16'h0, cpu_rdata}, {16'h0, model_mem[16'h0F0E]});
    chk("inflight_vga_data", {16'h0, vga_data}, {16'h0, model_mem[16'h0FF0]});
    step();
    cpu_req = 1'b0; vga_window = 1'b0;

    // Reset pulse while a read waits on the RAM.
    step();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0F0F;
    step();
    cpu_req = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("abort_rdata", {16'h0, cpu_rdata}, 32'h0);
    chk("abort_stall", {16'h0, stall_count}, 32'h0);
    rst_n = 1'b1;
    stall_total = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_ack", {31'h0, cpu_ack}, 32'h0);
    end
    cpu_op(1'b0, 16'h0F0F, 16'h0, 0, lat, rd);
    chk("post_abort_lat", lat, 2);
    chk("post_abort_rdata", {16'h0, rd}, 32'h1234);

    // Random traffic against the shadow model.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] exp_rd;
      we = 1'($urandom_range(0, 1));
      a  = 16'h0F00 + 16'($urandom_range(0, 31));
      exp_rd = model_mem[a];
      cpu_op(we, a, 16'($urandom), $urandom_range(0, 3), lat, rd);
      chk("rand_lat", lat, we ? 1 : 2);
      if (!we) chk("rand_rdata", {16'h0, rd}, {16'h0, exp_rd});
      if ($urandom_range(0, 1) == 1) vga_probe(16'h0F00 + 16'($urandom_range(0, 31)));
    end
    check_stall_count("stall_after_random");

`ifdef STALL_COUNT_EN
    step();
    cpu_req = 1'b1; cpu_we = 1'b1; vga_window = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    cpu_req = 1'b0;
    add_stall(70000);
    @(negedge clk);
    chk("stall_saturate", {16'h0, stall_count}, 32'hFFFF);
    vga_window = 1'b0;
`endif
    step();
    check_stall_count("stall_final");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
